// File: rtl/vending_machine_gen.sv
// Coin-operated vending controller: credits coins, vends a latched selection once paid, pays change greedily.
// Coin/selection effects register one cycle after their inputs; change_valid holds its coin until change_ready.
module vending_machine_gen #(
    parameter int NUM_ITEMS  = 6,
    parameter int SEL_W      = 3,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd15, 8'd25, 8'd50, 8'd75, 8'd85, 8'd100}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_error,
    output logic                dispense_valid,
    output logic [SEL_W-1:0]    dispense_id,
    output logic                change_valid,
    output logic [1:0]          change_code,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic                pend_vld, pend_vld_nxt;
    logic [SEL_W-1:0]    pend_id, pend_id_nxt;
    logic                reject_q, reject_nxt;
    logic                error_q, error_nxt;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                sel_in_range;
    logic [1:0]          chg_code;
    logic [CREDIT_W-1:0] chg_val;

    function automatic logic [CREDIT_W-1:0] coin_val(input logic [1:0] code);
        case (code)
            2'd0:    coin_val = CREDIT_W'(5);
            2'd1:    coin_val = CREDIT_W'(10);
            2'd2:    coin_val = CREDIT_W'(25);
            default: coin_val = CREDIT_W'(100);
        endcase
    endfunction

    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] id);
        price_of = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (id == SEL_W'(i)) price_of = PRICES[i*CREDIT_W +: CREDIT_W];
        end
    endfunction

    // One extra bit so an over-limit coin is detected instead of wrapping.
    assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_val(coin_code)};
    assign coin_fits    = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign sel_in_range = int'(sel_id) < NUM_ITEMS;

    always_comb begin
        chg_code = 2'd0;
        if (credit_q >= CREDIT_W'(100))     chg_code = 2'd3;
        else if (credit_q >= CREDIT_W'(25)) chg_code = 2'd2;
        else if (credit_q >= CREDIT_W'(10)) chg_code = 2'd1;
        chg_val = coin_val(chg_code);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit_q <= '0;
            pend_vld <= 1'b0;
            pend_id  <= '0;
            reject_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit_q <= credit_nxt;
            pend_vld <= pend_vld_nxt;
            pend_id  <= pend_id_nxt;
            reject_q <= reject_nxt;
            error_q  <= error_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit_q;
        pend_vld_nxt = pend_vld;
        pend_id_nxt  = pend_id;
        reject_nxt   = 1'b0;
        error_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_fits) credit_nxt = coin_sum[CREDIT_W-1:0];
                    else           reject_nxt = 1'b1;
                end
                if (sel_valid) begin
                    if (sel_in_range) begin
                        pend_vld_nxt = 1'b1;
                        pend_id_nxt  = sel_id;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
                // Cancel outranks a same-cycle selection; the affordability test sees this cycle's coin.
                if (cancel) begin
                    pend_vld_nxt = 1'b0;
                    if (credit_nxt != '0) state_nxt = CHANGE;
                end else if (pend_vld_nxt && price_of(pend_id_nxt) <= credit_nxt) begin
                    state_nxt = DISPENSE;
                end
            end
            DISPENSE: begin
                reject_nxt   = coin_valid;
                pend_vld_nxt = 1'b0;
                credit_nxt   = (price_of(pend_id) > credit_q) ? '0 : credit_q - price_of(pend_id);
                state_nxt    = (credit_nxt != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_nxt = coin_valid;
                if (change_ready) begin
                    credit_nxt = (chg_val > credit_q) ? '0 : credit_q - chg_val;
                    if (credit_nxt == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        credit         = credit_q;
        coin_reject    = reject_q;
        sel_error      = error_q;
        busy           = state != IDLE;
        dispense_valid = state == DISPENSE;
        dispense_id    = (state == DISPENSE) ? pend_id : '0;
        change_valid   = state == CHANGE;
        change_code    = (state == CHANGE) ? chg_code : 2'd0;
    end

endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed-vector bench for vending_machine_gen; inputs change and outputs are sampled 1ns after each rising edge.
module tb_vending_machine_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'd0;
    logic       sel_valid = 1'b0;
    logic [2:0] sel_id = 3'd0;
    logic       cancel = 1'b0;
    logic       change_ready = 1'b0;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_error;
    logic       dispense_valid;
    logic [2:0] dispense_id;
    logic       change_valid;
    logic [1:0] change_code;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    vending_machine_gen dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_code(coin_code),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .change_ready(change_ready),
        .credit(credit), .coin_reject(coin_reject), .sel_error(sel_error),
        .dispense_valid(dispense_valid), .dispense_id(dispense_id),
        .change_valid(change_valid), .change_code(change_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [2:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        vectors++; if (credit !== 8'd0) begin $display("FAIL reset_credit: got %0d expected 0", credit); miscompares++; end
        vectors++; if ({busy, dispense_valid, change_valid, coin_reject, sel_error} !== 5'b0) begin
            $display("FAIL reset_flags: got %b expected 00000", {busy, dispense_valid, change_valid, coin_reject, sel_error}); miscompares++; end
        vectors++; if ({dispense_id, change_code} !== 5'b0) begin
            $display("FAIL reset_codes: got id %0d code %0d expected 0 0", dispense_id, change_code); miscompares++; end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exact_pay();
        insert_coin(2'd2); insert_coin(2'd2); insert_coin(2'd2); insert_coin(2'd1);
        vectors++; if (credit !== 8'd85) begin $display("FAIL exact_credit: got %0d expected 85", credit); miscompares++; end
        select(3'd1);
        vectors++; if (dispense_valid !== 1'b1 || dispense_id !== 3'd1) begin
            $display("FAIL exact_dispense: got vld %b id %0d expected 1 1", dispense_valid, dispense_id); miscompares++; end
        tick();
        vectors++; if (dispense_valid !== 1'b0 || credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL exact_after: got vld %b credit %0d chg %b busy %b expected 0 0 0 0", dispense_valid, credit, change_valid, busy); miscompares++; end
    endtask

    task automatic test_select_first();
        select(3'd0);
        vectors++; if (dispense_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL selfirst_wait: got vld %b busy %b expected 0 0", dispense_valid, busy); miscompares++; end
        insert_coin(2'd3);
        vectors++; if (dispense_valid !== 1'b1 || dispense_id !== 3'd0 || credit !== 8'd100) begin
            $display("FAIL selfirst_dispense: got vld %b id %0d credit %0d expected 1 0 100", dispense_valid, dispense_id, credit); miscompares++; end
        tick();
        vectors++; if (credit !== 8'd0 || busy !== 1'b0) begin
            $display("FAIL selfirst_after: got credit %0d busy %b expected 0 0", credit, busy); miscompares++; end
    endtask

    task automatic test_change_greedy();
        logic [1:0] exp_code [4] = '{2'd2, 2'd2, 2'd2, 2'd1};
        insert_coin(2'd3);
        change_ready = 1'b1;
        select(3'd5);
        vectors++; if (dispense_valid !== 1'b1 || dispense_id !== 3'd5) begin
            $display("FAIL greedy_dispense: got vld %b id %0d expected 1 5", dispense_valid, dispense_id); miscompares++; end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (change_valid !== 1'b1 || change_code !== exp_code[i]) begin
                $display("FAIL greedy_coin%0d: got vld %b code %0d expected 1 %0d", i, change_valid, change_code, exp_code[i]); miscompares++; end
            tick();
        end
        vectors++; if (change_valid !== 1'b0 || change_code !== 2'd0 || credit !== 8'd0 || busy !== 1'b0) begin
            $display("FAIL greedy_done: got vld %b code %0d credit %0d busy %b expected 0 0 0 0", change_valid, change_code, credit, busy); miscompares++; end
        change_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int waited;
        insert_coin(2'd3); insert_coin(2'd2); insert_coin(2'd2); insert_coin(2'd2); insert_coin(2'd1); insert_coin(2'd1);
        vectors++; if (credit !== 8'd195) begin $display("FAIL ovf_credit: got %0d expected 195", credit); miscompares++; end
        insert_coin(2'd2);
        vectors++; if (coin_reject !== 1'b1 || credit !== 8'd195) begin
            $display("FAIL ovf_reject: got rej %b credit %0d expected 1 195", coin_reject, credit); miscompares++; end
        tick();
        vectors++; if (coin_reject !== 1'b0) begin $display("FAIL ovf_pulse: got %b expected 0", coin_reject); miscompares++; end
        cancel = 1'b1; tick(); cancel = 1'b0;
        vectors++; if (change_valid !== 1'b1 || change_code !== 2'd3) begin
            $display("FAIL ovf_refund: got vld %b code %0d expected 1 3", change_valid, change_code); miscompares++; end
        insert_coin(2'd0);
        vectors++; if (coin_reject !== 1'b1 || credit !== 8'd195) begin
            $display("FAIL change_coin_reject: got rej %b credit %0d expected 1 195", coin_reject, credit); miscompares++; end
        change_ready = 1'b1;
        waited = 0;
        while (busy === 1'b1 && waited < 20) begin tick(); waited++; end
        change_ready = 1'b0;
        vectors++; if (busy !== 1'b0 || credit !== 8'd0 || waited !== 6) begin
            $display("FAIL ovf_drain: got busy %b credit %0d cycles %0d expected 0 0 6", busy, credit, waited); miscompares++; end
    endtask

    task automatic test_cancel_hold();
        insert_coin(2'd2); insert_coin(2'd1); insert_coin(2'd0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (change_valid !== 1'b1 || change_code !== 2'd2 || credit !== 8'd40) begin
                $display("FAIL hold_stable%0d: got vld %b code %0d credit %0d expected 1 2 40", i, change_valid, change_code, credit); miscompares++; end
            tick();
        end
        change_ready = 1'b1;
        tick();
        vectors++; if (change_code !== 2'd1 || credit !== 8'd15) begin
            $display("FAIL hold_second: got code %0d credit %0d expected 1 15", change_code, credit); miscompares++; end
        tick();
        vectors++; if (change_code !== 2'd0 || change_valid !== 1'b1 || credit !== 8'd5) begin
            $display("FAIL hold_third: got vld %b code %0d credit %0d expected 1 0 5", change_valid, change_code, credit); miscompares++; end
        tick();
        change_ready = 1'b0;
        vectors++; if (change_valid !== 1'b0 || credit !== 8'd0) begin
            $display("FAIL hold_done: got vld %b credit %0d expected 0 0", change_valid, credit); miscompares++; end
    endtask

    task automatic test_sel_error();
        select(3'd3);
        select(3'd7);
        vectors++; if (sel_error !== 1'b1) begin $display("FAIL selerr_pulse: got %b expected 1", sel_error); miscompares++; end
        tick();
        vectors++; if (sel_error !== 1'b0) begin $display("FAIL selerr_clear: got %b expected 0", sel_error); miscompares++; end
        insert_coin(2'd3);
        vectors++; if (dispense_valid !== 1'b1 || dispense_id !== 3'd3) begin
            $display("FAIL selerr_pending: got vld %b id %0d expected 1 3", dispense_valid, dispense_id); miscompares++; end
        change_ready = 1'b1;
        tick(); tick(); tick();
        change_ready = 1'b0;
        vectors++; if (busy !== 1'b0 || credit !== 8'd0) begin
            $display("FAIL selerr_change: got busy %b credit %0d expected 0 0", busy, credit); miscompares++; end
    endtask

    task automatic test_cancel_zero();
        select(3'd4);
        cancel = 1'b1; tick(); cancel = 1'b0;
        vectors++; if (busy !== 1'b0) begin $display("FAIL cancel0_busy: got %b expected 0", busy); miscompares++; end
        insert_coin(2'd2);
        vectors++; if (dispense_valid !== 1'b0 || credit !== 8'd25) begin
            $display("FAIL cancel0_cleared: got vld %b credit %0d expected 0 25", dispense_valid, credit); miscompares++; end
        coin_valid = 1'b1; coin_code = 2'd1; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; cancel = 1'b0;
        vectors++; if (change_valid !== 1'b1 || change_code !== 2'd2 || credit !== 8'd35) begin
            $display("FAIL cancel_coin: got vld %b code %0d credit %0d expected 1 2 35", change_valid, change_code, credit); miscompares++; end
    endtask

    task automatic test_reset_mid_change();
        vectors++; if (busy !== 1'b1) begin $display("FAIL midrst_setup: got busy %b expected 1", busy); miscompares++; end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (change_valid !== 1'b0 || change_code !== 2'd0 || busy !== 1'b0 || credit !== 8'd0) begin
            $display("FAIL midrst_now: got vld %b code %0d busy %b credit %0d expected 0 0 0 0", change_valid, change_code, busy, credit); miscompares++; end
        change_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        change_ready = 1'b0;
        vectors++; if (change_valid !== 1'b0 || busy !== 1'b0 || credit !== 8'd0) begin
            $display("FAIL midrst_after: got vld %b busy %b credit %0d expected 0 0 0", change_valid, busy, credit); miscompares++; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_exact_pay();
        test_select_first();
        test_change_greedy();
        test_overflow();
        test_cancel_hold();
        test_sel_error();
        test_cancel_zero();
        test_reset_mid_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
